// File: rtl/ultrasonic_scanner_if.sv
// Sensor-side bundle of the scanner: scan enable, echo inputs, triggers and tagged result stream.
// master = scanner core, slave = sensors plus downstream consumer.
interface ultrasonic_scanner_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 24,
   parameter int CH_W  = 2
);
   logic             ready_i;
   logic [N_CH-1:0]  echo_i;
   logic [N_CH-1:0]  trigger_o;
   logic [CNT_W-1:0] meas_o;
   logic [CH_W-1:0]  meas_ch_o;
   logic             meas_valid_o;
   logic             timeout_o;
   logic             busy_o;

   modport master (
      input  ready_i, echo_i,
      output trigger_o, meas_o, meas_ch_o, meas_valid_o, timeout_o, busy_o
   );

   modport slave (
      output ready_i, echo_i,
      input  trigger_o, meas_o, meas_ch_o, meas_valid_o, timeout_o, busy_o
   );
endinterface

// File: rtl/ultrasonic_scanner.sv
// Round-robin HC-SR04 scanner: trigger, echo-width measurement, timeout and inter-ping gap per channel.
// Result valid 3 edges after the echo falls; no backpressure, results are single-cycle pulses.
module ultrasonic_scanner #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 24,
   parameter int TIME_TRIG    = 500,
   parameter int TIME_TIMEOUT = 1500000,
   parameter int TIME_GAP     = 500000
) (
   input  logic                   clk,
   input  logic                   rst,
   ultrasonic_scanner_if.master   bus
);
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CH_SPAN = 1 << CH_W;

   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TIME_TRIG - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIME_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(TIME_GAP - 1);
   localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  width_q, width_d;
   logic [N_CH-1:0]   sync1_q, sync1_d;
   logic [N_CH-1:0]   sync2_q, sync2_d;
   logic [N_CH-1:0]   dly_q, dly_d;
   logic [CNT_W-1:0]  meas_q, meas_d;
   logic [CH_W-1:0]   meas_ch_q, meas_ch_d;
   logic              meas_valid_q, meas_valid_d;
   logic              timeout_q, timeout_d;

   logic [CH_SPAN-1:0] sync2_ext;
   logic [CH_SPAN-1:0] dly_ext;
   logic               echo_cur;
   logic               echo_rise;
   logic               echo_fall;
   logic [N_CH-1:0]    trig_vec;

   // Only the active channel is observed; padding keeps the index in range for any N_CH.
   always_comb begin
      sync2_ext = CH_SPAN'(sync2_q);
      dly_ext   = CH_SPAN'(dly_q);
      echo_cur  = sync2_ext[ch_q];
      echo_rise = sync2_ext[ch_q] & ~dly_ext[ch_q];
      echo_fall = ~sync2_ext[ch_q] & dly_ext[ch_q];
   end

   always_comb begin
      sync1_d      = bus.echo_i;
      sync2_d      = sync1_q;
      dly_d        = sync2_q;
      state_d      = state_q;
      ch_d         = ch_q;
      timer_d      = timer_q;
      width_d      = width_q;
      meas_d       = meas_q;
      meas_ch_d    = meas_ch_q;
      meas_valid_d = 1'b0;
      timeout_d    = timeout_q;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (bus.ready_i) begin
               state_d = ST_TRIG;
            end
         end

         ST_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               timer_d = '0;
               state_d = ST_WAIT_RISE;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end

         // The timeout budget spans both waiting and measuring; a fall in the
         // timeout cycle still reports the real width.
         ST_WAIT_RISE, ST_MEASURE: begin
            if ((state_q == ST_MEASURE) && echo_fall) begin
               meas_d       = width_q;
               meas_ch_d    = ch_q;
               meas_valid_d = 1'b1;
               timeout_d    = 1'b0;
               timer_d      = '0;
               state_d      = ST_GAP;
            end else if (timer_q == TO_LAST) begin
               meas_d       = ALL_ONES;
               meas_ch_d    = ch_q;
               meas_valid_d = 1'b1;
               timeout_d    = 1'b1;
               timer_d      = '0;
               state_d      = ST_GAP;
            end else begin
               timer_d = timer_q + CNT_W'(1);
               if ((state_q == ST_WAIT_RISE) && echo_rise) begin
                  width_d = CNT_W'(1);
                  state_d = ST_MEASURE;
               end else if ((state_q == ST_MEASURE) && echo_cur && (width_q != ALL_ONES)) begin
                  width_d = width_q + CNT_W'(1);
               end
            end
         end

         ST_GAP: begin
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         timer_q      <= '0;
         width_q      <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         dly_q        <= '0;
         meas_q       <= '0;
         meas_ch_q    <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         timer_q      <= timer_d;
         width_q      <= width_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         dly_q        <= dly_d;
         meas_q       <= meas_d;
         meas_ch_q    <= meas_ch_d;
         meas_valid_q <= meas_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      trig_vec = '0;
      if (state_q == ST_TRIG) begin
         trig_vec = N_CH'(1) << ch_q;
      end
   end

   assign bus.trigger_o    = trig_vec;
   assign bus.meas_o       = meas_q;
   assign bus.meas_ch_o    = meas_ch_q;
   assign bus.meas_valid_o = meas_valid_q;
   assign bus.timeout_o    = timeout_q;
   assign bus.busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Directed bench for ultrasonic_scanner: two channels, short trigger/timeout/gap, hand-computed timing.
module tb_ultrasonic_scanner;
   localparam int N_CH         = 2;
   localparam int CNT_W        = 24;
   localparam int TIME_TRIG    = 5;
   localparam int TIME_TIMEOUT = 100;
   localparam int TIME_GAP     = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   valid_cnt = 0;

   ultrasonic_scanner_if #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(1)) bus ();

   ultrasonic_scanner #(
      .N_CH(N_CH), .CNT_W(CNT_W), .TIME_TRIG(TIME_TRIG),
      .TIME_TIMEOUT(TIME_TIMEOUT), .TIME_GAP(TIME_GAP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.meas_valid_o === 1'b1) valid_cnt <= valid_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_trig(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < 200) begin
         step(1);
         n++;
         if (bus.trigger_o != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Starts on a cycle with trigger high; ends on the first cycle of WAIT_RISE.
   task automatic count_trig(input logic [1:0] exp, output int len, output bit pat_ok);
      len    = 0;
      pat_ok = 1'b1;
      while ((bus.trigger_o != '0) && (len < 50)) begin
         if (bus.trigger_o !== exp) pat_ok = 1'b0;
         len++;
         step(1);
      end
   endtask

   task automatic test_reset;
      logic [29:0] obs;
      rst = 1'b1;
      bus.ready_i = 1'b0;
      bus.echo_i  = '0;
      step(3);
      obs = {bus.trigger_o, bus.meas_o, bus.meas_ch_o, bus.meas_valid_o, bus.timeout_o, bus.busy_o};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         obs = {bus.trigger_o, bus.meas_o, bus.meas_ch_o, bus.meas_valid_o, bus.timeout_o, bus.busy_o};
         checks++;
         if (obs !== '0) begin errors++; $display("FAIL idle_outputs cycle %0d got %h want 0", i, obs); end
      end
   endtask

   task automatic test_single_ping;
      int n; int len; bit ok; bit pat;
      bus.ready_i = 1'b1;
      wait_trig(n, ok);
      checks++;
      if (!ok || n !== 1) begin errors++; $display("FAIL ping0_start got %0d want 1", n); end
      count_trig(2'b01, len, pat);
      checks++;
      if (len !== 5 || !pat) begin errors++; $display("FAIL ping0_trig_len got %0d (pattern ok %0d) want 5", len, pat); end
      bus.echo_i[0] = 1'b1;
      step(20);
      bus.echo_i[0] = 1'b0;
      step(2);
      checks++;
      if (bus.meas_valid_o !== 1'b0) begin errors++; $display("FAIL ping0_early_valid got %b want 0", bus.meas_valid_o); end
      step(1);
      checks++;
      if (bus.meas_valid_o !== 1'b1 || bus.meas_o !== 24'd20 || bus.meas_ch_o !== 1'b0 || bus.timeout_o !== 1'b0)
         begin errors++; $display("FAIL ping0_result got v=%b m=%0d ch=%0d to=%b want v=1 m=20 ch=0 to=0",
                bus.meas_valid_o, bus.meas_o, bus.meas_ch_o, bus.timeout_o); end
      step(1);
      checks++;
      if (bus.meas_valid_o !== 1'b0 || bus.meas_o !== 24'd20) begin errors++;
         $display("FAIL ping0_pulse_hold got v=%b m=%0d want v=0 m=20", bus.meas_valid_o, bus.meas_o); end
   endtask

   task automatic test_scan_timeout;
      int n; int len; bit ok; bit pat;
      wait_trig(n, ok);
      checks++;
      if (!ok || n !== 10 || bus.trigger_o !== 2'b10) begin errors++;
         $display("FAIL ping1_start got %0d trig=%b want 10 trig=10", n, bus.trigger_o); end
      count_trig(2'b10, len, pat);
      checks++;
      if (len !== 5 || !pat) begin errors++; $display("FAIL ping1_trig_len got %0d (pattern ok %0d) want 5", len, pat); end
      n = 0;
      while (n < 150) begin
         bus.echo_i[0] = n[2];
         step(1);
         n++;
         if (bus.meas_valid_o === 1'b1) break;
      end
      checks++;
      if (n !== 100) begin errors++; $display("FAIL timeout_latency got %0d want 100", n); end
      checks++;
      if (bus.meas_o !== 24'hFFFFFF || bus.meas_ch_o !== 1'b1 || bus.timeout_o !== 1'b1)
         begin errors++; $display("FAIL timeout_result got m=%h ch=%0d to=%b want m=ffffff ch=1 to=1",
                bus.meas_o, bus.meas_ch_o, bus.timeout_o); end
      bus.echo_i[0] = 1'b1;
   endtask

   task automatic test_pre_high;
      int n; int len; bit ok; bit pat; int base;
      wait_trig(n, ok);
      checks++;
      if (!ok || n !== 11 || bus.trigger_o !== 2'b01) begin errors++;
         $display("FAIL ping2_start got %0d trig=%b want 11 trig=01", n, bus.trigger_o); end
      count_trig(2'b01, len, pat);
      base = valid_cnt;
      step(5);
      bus.echo_i[0] = 1'b0;
      step(5);
      checks++;
      if (valid_cnt !== base || bus.busy_o !== 1'b1) begin errors++;
         $display("FAIL prehigh_ignored got pulses=%0d busy=%b want 0 busy=1", valid_cnt - base, bus.busy_o); end
      bus.echo_i[0] = 1'b1;
      step(7);
      bus.echo_i[0] = 1'b0;
      step(3);
      checks++;
      if (bus.meas_valid_o !== 1'b1 || bus.meas_o !== 24'd7 || bus.meas_ch_o !== 1'b0 || bus.timeout_o !== 1'b0)
         begin errors++; $display("FAIL prehigh_result got v=%b m=%0d ch=%0d to=%b want v=1 m=7 ch=0 to=0",
                bus.meas_valid_o, bus.meas_o, bus.meas_ch_o, bus.timeout_o); end
   endtask

   task automatic test_reset_mid(output int base);
      int n; int len; bit ok; bit pat;
      wait_trig(n, ok);
      count_trig(2'b10, len, pat);
      bus.echo_i[1] = 1'b1;
      step(6);
      base = valid_cnt;
      rst = 1'b1;
      step(1);
      checks++;
      if (bus.trigger_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.meas_valid_o !== 1'b0 || bus.meas_o !== '0)
         begin errors++; $display("FAIL midreset_outputs got trig=%b busy=%b v=%b m=%0d want all 0",
                bus.trigger_o, bus.busy_o, bus.meas_valid_o, bus.meas_o); end
      rst = 1'b0;
      bus.echo_i[1] = 1'b0;
      wait_trig(n, ok);
      checks++;
      if (!ok || n !== 1 || bus.trigger_o !== 2'b01) begin errors++;
         $display("FAIL postreset_ch got %0d trig=%b want 1 trig=01", n, bus.trigger_o); end
   endtask

   task automatic test_ready_drop(input int base);
      int len; bit pat;
      bus.ready_i = 1'b0;
      count_trig(2'b01, len, pat);
      checks++;
      if (len !== 5 || !pat) begin errors++; $display("FAIL drop_trig_len got %0d (pattern ok %0d) want 5", len, pat); end
      bus.echo_i[0] = 1'b1;
      step(12);
      bus.echo_i[0] = 1'b0;
      step(3);
      checks++;
      if (bus.meas_valid_o !== 1'b1 || bus.meas_o !== 24'd12 || bus.meas_ch_o !== 1'b0 || bus.timeout_o !== 1'b0)
         begin errors++; $display("FAIL drop_result got v=%b m=%0d ch=%0d to=%b want v=1 m=12 ch=0 to=0",
                bus.meas_valid_o, bus.meas_o, bus.meas_ch_o, bus.timeout_o); end
      step(9);
      checks++;
      if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL drop_gap_busy got %b want 1", bus.busy_o); end
      step(1);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.trigger_o !== 2'b00) begin errors++;
         $display("FAIL drop_idle got busy=%b trig=%b want 0 00", bus.busy_o, bus.trigger_o); end
      step(20);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.trigger_o !== 2'b00 || valid_cnt !== base + 1) begin errors++;
         $display("FAIL drop_parked got busy=%b trig=%b pulses=%0d want 0 00 1",
                bus.busy_o, bus.trigger_o, valid_cnt - base); end
      bus.ready_i = 1'b1;
      step(1);
      checks++;
      if (bus.trigger_o !== 2'b10) begin errors++; $display("FAIL resume_ch1 got %b want 10", bus.trigger_o); end
   endtask

   initial begin
      int base;
      bus.ready_i = 1'b0;
      bus.echo_i  = '0;
      test_reset();
      test_single_ping();
      test_scan_timeout();
      test_pre_high();
      test_reset_mid(base);
      test_ready_drop(base);
      bus.ready_i = 1'b0;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ultrasonic_scanner.md
Name: ultrasonic_scanner

Overview:
Parametrised multi-channel successor to the single-sensor ultrasonic controller. It drives N_CH HC-SR04-style sensors in round-robin order. For each ping it fires one trigger pulse, measures the echo high-time in clock cycles, detects timeouts and enforces an inter-ping gap. Results are presented as a tagged, single-cycle-valid measurement stream for the downstream distance/display logic.

Parameters:
- N_CH, 4, number of sensor channels (≥1).
- CNT_W, 24, width of the measurement and internal counters.
- TIME_TRIG, 500, trigger pulse length in clk cycles (≥1).
- TIME_TIMEOUT, 1500000, maximum cycles from trigger end to echo fall (≥2, < 2^CNT_W).
- TIME_GAP, 500000, idle cycles after each result before the next ping (≥1).
- CH_W (localparam), max(1, clog2(N_CH)), channel index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ready_i  in  1  scan enable; sampled only in IDLE.
- echo_i  in  N_CH  asynchronous echo inputs, one per sensor.
- trigger_o  out  N_CH  one-hot trigger; only the active channel bit can be high.
- meas_o  out  CNT_W  echo high-time in cycles; all-ones on timeout.
- meas_ch_o  out  CH_W  channel that meas_o belongs to.
- meas_valid_o  out  1  one-cycle pulse; meas_o, meas_ch_o and timeout_o are valid in this cycle.
- timeout_o  out  1  result came from a timeout.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, active channel 0, all counters 0, synchronizer flops 0. trigger_o, meas_o, meas_ch_o, meas_valid_o, timeout_o and busy_o are all 0. Reset mid-operation aborts immediately; no result is produced.
- Echo path: two-flop synchronizer per channel, then a registered delayed copy for edge detection. Only the active channel is observed; edges on other channels are ignored.
- States:
  - IDLE: if ready_i=1, go to TRIG; otherwise stay. The active channel is retained.
  - TRIG: trigger_o[ch]=1 for exactly TIME_TRIG cycles, then go to WAIT_RISE. Clear the timeout counter on entry to WAIT_RISE.
  - WAIT_RISE: wait for a synchronized rising edge on the active channel, then go to MEASURE with the width counter set to 1. An echo that is already high on entry is not a rising edge; the block waits for low→high.
  - MEASURE: increment the width counter each cycle the synchronized echo stays high, saturating at all-ones. On the synchronized falling edge: meas_o = width, timeout_o=0, meas_valid_o=1 for one cycle, then go to GAP. An echo high for H cycles yields meas_o=H.
  - Timeout: the timeout counter runs through WAIT_RISE and MEASURE. When it reaches TIME_TIMEOUT-1 without a falling edge: meas_o = all-ones, timeout_o=1, meas_valid_o=1, then go to GAP. If the timeout and the falling edge occur in the same cycle, the falling edge wins.
  - GAP: count TIME_GAP cycles, then advance the channel (N_CH-1 wraps to 0) and return to IDLE.
- Latency: meas_valid_o is high in the cycle after the 3rd rising clk edge, counting the edge that first samples echo_i low as edge 1.
- meas_o, meas_ch_o and timeout_o hold their values until the next valid pulse.
- ready_i deasserted mid-ping: the current ping and its gap complete normally; the block then parks in IDLE on the next channel.
- N_CH=1: the channel stays 0 and the block behaves as a single-sensor controller with a timeout.

Test Plan:
All scenarios use N_CH=2, TIME_TRIG=5, TIME_TIMEOUT=100, TIME_GAP=10, 10 ns clk.

1. Reset, then hold ready_i=0 for 50 cycles → all outputs 0, busy_o=0, trigger_o=00.
2. Set ready_i=1. After the trigger ends, raise echo_i[0] for 20 cycles → trigger_o=01 for exactly 5 cycles; meas_valid_o pulses once with meas_o=20, meas_ch_o=0, timeout_o=0; pulse appears 3 edges after the echo fall.
3. Continue scanning → next trigger_o=10 starts 10 gap cycles after the valid pulse (plus one IDLE cycle). Toggle echo_i[0] during the ch1 ping with echo_i[1] silent → timeout result: meas_o=0xFFFFFF, meas_ch_o=1, timeout_o=1, valid 100 cycles after WAIT_RISE entry.
4. Hold echo_i[0] high from before the trigger, drop it, then re-raise it for 7 cycles → meas_o=7 (the pre-existing high is ignored).
5. Assert rst during MEASURE → next cycle: trigger_o=00, busy_o=0, no valid pulse. With ready_i=1 after release, the next ping fires on ch0.
6. Drop ready_i during TRIG on ch0 → the ch0 result is still delivered, then the block idles with busy_o=0. Re-enabling ready_i fires the trigger on ch1.
